nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead slice (cla4) over
//   WIDTH/4 cycles, least significant nibble first, with a registered carry between nibbles.
//   It is the operand sequencer that sits directly upstream of cla4. It is the area-reduced add
//   path for the MCU ALU, and it presents a start/busy/done handshake to the ALU control FSM.
// PARAMETERS
//   WIDTH  16  operand width in bits; must be a multiple of 4 and >= 8.
//   NIB    WIDTH/4 (localparam)  number of nibble passes.
// PORTS
//   clk    in   1      single clock; all state updates on the rising edge
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request a new operation; sampled only in IDLE
//   sub    in   1      0: a+b+cin; 1: a-b (the block computes a+~b+1 and ignores cin)
//   a      in   WIDTH  operand A; captured at the accept edge
//   b      in   WIDTH  operand B; captured at the accept edge
//   cin    in   1      carry-in for add; captured at the accept edge
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse when the result registers update
//   sum    out  WIDTH  result; holds its value until the next completion
//   cout   out  1      carry out of the MSB (for subtract, 1 = no borrow)
//   ovf    out  1      signed overflow
//   zero   out  1      high when sum == 0
// BEHAVIOUR
//   - Reset (asynchronous, rst_n=0): state=IDLE, count=0, all working regs=0.
//     Outputs reset to: busy=0, done=0, sum=0, cout=0, ovf=0, zero=0.
//   - FSM has two states, IDLE and RUN.
//       IDLE->RUN when start=1 (accept edge). At that edge:
//         opa<=a; opb<=sub?~b:b; carry<=sub?1:cin; count<=0.
//       RUN: each edge, cla4 computes nibble[count] of opa and opb with carry. Then:
//         work[4*count+:4]<=cla sum; carry<=cla cout; count<=count+1.
//       RUN->IDLE at the edge where count==NIB-1. At that same edge:
//         sum<=final work value (with the last nibble merged in); cout<=cla cout; done<=1.
//         ovf<=(opa[MSB]==opb[MSB]) & (result[MSB]!=opa[MSB]); zero<=(result==0).
//   - done is registered and deasserts at the next edge.
//   - busy is combinational: (state==RUN).
//   - Latency: done is high in the cycle that begins NIB edges after the accept edge
//     (4 cycles for WIDTH=16). Throughput is one operation per NIB cycles.
//   - Back-to-back: in the done cycle the state is IDLE, so start=1 there is accepted.
//     The new operation does not disturb sum/flags until its own done.
//   - start while busy: ignored (not queued); the in-flight operation is unaffected.
//   - Operand inputs may change freely after the accept edge.
//   - cla4 Pgrp/Ggrp outputs are unused.
//   - Reset mid-RUN: the operation is aborted and no done is generated. The block returns to
//     IDLE with the reset values above.
//   - Width rules: all arithmetic is modulo 2^WIDTH; cout is the bit-WIDTH carry.
// STRUCTURE
//   - Shared header alu_defs.vh holds the FSM state encodings (ST_IDLE=1'b0, ST_RUN=1'b1).
//   - Count width is $clog2(NIB), minimum 1.
//   - One sub-module instance: cla4 (a, b, cin -> sum, cout).
//     Nibble select is a registered-operand mux indexed by count.
//   - Target size: about 150 lines of RTL.
// TESTING  (WIDTH=16)
//   - Add: a=0x1234, b=0x4321, cin=0, sub=0 -> done exactly 4 cycles after accept.
//     Result: sum=0x5555, cout=0, ovf=0, zero=0; busy high for exactly 4 cycles.
//   - Wrap: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0.
//   - Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0.
//     Carry-in: a=0x000F, b=0, cin=1 -> sum=0x0010.
//   - Subtract: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0.
//     Subtract: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1, cout=1.
//   - Handshake: pulse start during RUN with other operands -> ignored; first result unchanged.
//     Then assert start in the done cycle -> accepted; second done 4 cycles later.
//   - Reset mid-RUN (rst_n low at count=2, asynchronous to clk) -> outputs zero immediately.
//     No done pulse follows; the next start behaves normally.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder: FSM state encoding and
// sizing of the nibble pass counter.
package nibble_serial_adder_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned NibW = 4;

    function automatic int unsigned cnt_width(input int unsigned nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Start/busy/done handshake plus operand and result bus of the nibble-serial adder.
// The master is the ALU control side and the slave is the adder.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead adder slice; all carries are formed directly from the
// generate/propagate terms and the incoming carry.
module nibble_serial_adder_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one cla4 slice is reused for WIDTH/4
// passes, least significant nibble first, with the carry held in a register.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int unsigned NIB = WIDTH / NibW;
    localparam int unsigned CW  = cnt_width(NIB);

    state_e           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_work;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [NibW-1:0]  w_nib_a;
    logic [NibW-1:0]  w_nib_b;
    logic [NibW-1:0]  w_cla_sum;
    logic             w_cla_cout;
    logic [WIDTH-1:0] w_result;
    logic             w_last;

    assign w_nib_a = r_opa[NibW*r_count +: NibW];
    assign w_nib_b = r_opb[NibW*r_count +: NibW];
    assign w_last  = (r_count == CW'(NIB - 1));

    nibble_serial_adder_cla4 u_cla4 (
        .i_a    (w_nib_a),
        .i_b    (w_nib_b),
        .i_cin  (r_carry),
        .o_sum  (w_cla_sum),
        .o_cout (w_cla_cout)
    );

    // Work register with the nibble being computed this cycle merged in.
    always_comb begin
        w_result = r_work;
        w_result[NibW*r_count +: NibW] = w_cla_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_count <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        // Subtract is a + ~b + 1; cin is ignored.
                        r_opa   <= bus.a;
                        r_opb   <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.sub ? 1'b1 : bus.cin;
                        r_count <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_work  <= w_result;
                    r_carry <= w_cla_cout;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_state <= StIdle;
                        r_count <= '0;
                        r_sum   <= w_result;
                        r_cout  <= w_cla_cout;
                        r_done  <= 1'b1;
                        r_ovf   <= (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                                   (w_result[WIDTH-1] != r_opa[WIDTH-1]);
                        r_zero  <= (w_result == '0);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy = (r_state == StRun);
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vector table,
// handshake and reset-abort sequences, and random operations against an arithmetic model.
module tb_nibble_serial_adder;
    localparam int unsigned W = 16;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [W-1:0] last_sum;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, output logic [W-1:0] sum, output logic cout,
                         output logic ovf, output logic zero);
        int ua, ub, sa, sb, ures, sres;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ures = ua - ub;
            sres = sa - sb;
            cout = (ua >= ub);
        end else begin
            ures = ua + ub + int'(cin);
            sres = sa + sb + int'(cin);
            cout = (ures >= 65536);
        end
        sum  = W'(ures & 32'hFFFF);
        ovf  = (sres > 32767) || (sres < -32768);
        zero = (sum == '0);
    endtask

    // Called at a negedge: launches one operation and waits (bounded) for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int glitch_at,
                          output int lat, output int busy_n);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.sub = sub;
        lat = -1;
        busy_n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.cin = 1'($urandom);
                bus.sub = 1'($urandom);
                check("sum_held_until_done", bus.sum, last_sum);
                check("done_single_pulse", bus.done, 1'b0);
            end
            if (k == glitch_at) begin
                bus.start = 1'b1;
                bus.a = 16'hFFFF;
                bus.b = 16'hFFFF;
                bus.sub = 1'b1;
            end else if (glitch_at > 0 && k == glitch_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                lat = k - 1;
                break;
            end
            if (bus.busy) busy_n++;
        end
        check("done_seen", (lat >= 0), 1'b1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] s, input logic c,
                                input logic o, input logic z);
        check({tag, "_sum"}, bus.sum, s);
        check({tag, "_cout"}, bus.cout, c);
        check({tag, "_ovf"}, bus.ovf, o);
        check({tag, "_zero"}, bus.zero, z);
        check({tag, "_busy_low"}, bus.busy, 1'b0);
        last_sum = s;
    endtask

    vec_t vecs [6];

    initial begin
        int lat, busy_n, seen_done;
        logic [W-1:0] ra, rb, es;
        logic rc, rs, ec, eo, ez;

        n_tests = 0;
        n_fail = 0;
        last_sum = '0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_sum", bus.sum, 16'h0000);
        check("rst_cout", bus.cout, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        check("rst_zero", bus.zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, lat, busy_n);
            check("vec_latency", lat, 4);
            check("vec_busy_cycles", busy_n, 4);
            check_result("vec", vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero);
            @(negedge clk);
        end

        // Start during RUN is ignored; start in the done cycle is accepted.
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 2, lat, busy_n);
        check("hs_latency", lat, 4);
        check_result("hs_first", 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op(16'h0100, 16'h0200, 1'b0, 1'b0, 0, lat, busy_n);
        check("b2b_latency", lat, 4);
        check("b2b_busy_cycles", busy_n, 4);
        check_result("b2b", 16'h0300, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Leave non-zero results, then abort an operation at count==2.
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, lat, busy_n);
        check_result("pre_abort", 16'h8000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'hFFFF;
        bus.b = 16'h0001;
        bus.sub = 1'b0;
        bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_sum", bus.sum, 16'h0000);
        check("abort_cout", bus.cout, 1'b0);
        check("abort_ovf", bus.ovf, 1'b0);
        check("abort_zero", bus.zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        last_sum = '0;
        seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, lat, busy_n);
        check("post_abort_latency", lat, 4);
        check_result("post_abort", 16'h5555, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (i % 10 == 0) rb = ~ra;
            if (i % 10 == 1) rb = ra;
            model(ra, rb, rc, rs, es, ec, eo, ez);
            run_op(ra, rb, rc, rs, 0, lat, busy_n);
            check("rnd_latency", lat, 4);
            check_result("rnd", es, ec, eo, ez);
            if (i % 3 == 0) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
